// File: rtl/adder_tree_frame_packer_if.sv
// Stream-side and frame-side bundle of the adder_tree frame packer.
// Valid/ready: a transfer happens on a posedge where valid && ready; a source holds its payload stable until then.
interface adder_tree_frame_packer_if #(
  parameter int DATA_W = 3,
  parameter int DATA_N = 9
);
  localparam int LANE_W = $clog2(DATA_N + 1);

  logic [DATA_W-1:0]              i_s_data;
  logic                           i_s_valid;
  logic                           i_s_last;
  logic                           o_s_ready;
  logic [0:DATA_N-1][DATA_W-1:0]  o_m_data;
  logic                           o_m_valid;
  logic [LANE_W-1:0]              o_m_lanes;
  logic                           i_m_ready;
  logic                           dbg_state;
  logic [LANE_W-1:0]              dbg_idx;

  modport master (
    input  i_s_data, i_s_valid, i_s_last, i_m_ready,
    output o_s_ready, o_m_data, o_m_valid, o_m_lanes, dbg_state, dbg_idx
  );

  modport slave (
    output i_s_data, i_s_valid, i_s_last, i_m_ready,
    input  o_s_ready, o_m_data, o_m_valid, o_m_lanes, dbg_state, dbg_idx
  );
endinterface

// File: rtl/adder_tree_frame_packer.sv
// Packs DATA_N streamed samples into one lane vector for the adder_tree.
// A fill buffer plus an output register let input run at full rate while downstream keeps up.
module adder_tree_frame_packer #(
  parameter int DATA_W = 3,
  parameter int DATA_N = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adder_tree_frame_packer_if.master bus
);
  localparam int LANE_W = $clog2(DATA_N + 1);

  typedef enum logic {FILLING = 1'b0, HELD = 1'b1} fill_state_e;

  fill_state_e                   state_q, state_d;
  logic [LANE_W-1:0]             idx_q, idx_d;
  logic [0:DATA_N-1][DATA_W-1:0] fill_q, fill_d;
  logic [LANE_W-1:0]             fill_lanes_q, fill_lanes_d;
  logic [0:DATA_N-1][DATA_W-1:0] out_data_q, out_data_d;
  logic [LANE_W-1:0]             out_lanes_q, out_lanes_d;
  logic                          out_valid_q, out_valid_d;
  logic                          ready_q, ready_d;

  logic                          accept, drain, close, load;
  logic [0:DATA_N-1][DATA_W-1:0] frame_c;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    fill_lanes_d = fill_lanes_q;
    out_data_d   = out_data_q;
    out_lanes_d  = out_lanes_q;
    load         = 1'b0;

    accept = bus.i_s_valid && ready_q;
    drain  = out_valid_q && bus.i_m_ready;
    close  = accept && ((idx_q == LANE_W'(DATA_N - 1)) || bus.i_s_last);

    // Closing frame: current sample in lane idx, lanes above it zeroed so a short frame sums correctly.
    frame_c        = fill_q;
    frame_c[idx_q] = bus.i_s_data;
    for (int l = 0; l < DATA_N; l++) begin
      if (LANE_W'(l) > idx_q) frame_c[l] = '0;
    end

    case (state_q)
      FILLING: begin
        if (close) begin
          idx_d = '0;
          if (!out_valid_q || drain) begin
            load        = 1'b1;
            out_data_d  = frame_c;
            out_lanes_d = idx_q + LANE_W'(1);
            fill_d      = '0;
          end else begin
            fill_d       = frame_c;
            fill_lanes_d = idx_q + LANE_W'(1);
            state_d      = HELD;
          end
        end else if (accept) begin
          fill_d[idx_q] = bus.i_s_data;
          idx_d         = idx_q + LANE_W'(1);
        end
      end
      HELD: begin
        if (drain) begin
          load         = 1'b1;
          out_data_d   = fill_q;
          out_lanes_d  = fill_lanes_q;
          fill_d       = '0;
          fill_lanes_d = '0;
          state_d      = FILLING;
        end
      end
      default: state_d = FILLING;
    endcase

    out_valid_d = load || (out_valid_q && !drain);
    ready_d     = (state_d == FILLING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILLING;
      idx_q        <= '0;
      fill_q       <= '0;
      fill_lanes_q <= '0;
      out_data_q   <= '0;
      out_lanes_q  <= '0;
      out_valid_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      fill_lanes_q <= fill_lanes_d;
      out_data_q   <= out_data_d;
      out_lanes_q  <= out_lanes_d;
      out_valid_q  <= out_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.o_s_ready = ready_q;
  assign bus.o_m_data  = out_data_q;
  assign bus.o_m_lanes = out_lanes_q;
  assign bus.o_m_valid = out_valid_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_idx   = idx_q;
endmodule

// File: tb/tb_adder_tree_frame_packer.sv
// Bench for adder_tree_frame_packer: directed steps plus random traffic against a sample-list frame model.
module tb_adder_tree_frame_packer;
  localparam int DW = 3;
  localparam int DN = 9;
  localparam int LW = $clog2(DN + 1);
  localparam int FW = LW + DN * DW;

  logic clk;
  logic rst_n;

  adder_tree_frame_packer_if #(.DATA_W(DW), .DATA_N(DN)) bus ();

  adder_tree_frame_packer #(.DATA_W(DW), .DATA_N(DN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;

  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] cur_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: frames are cut from the accepted sample list at DN samples or at last
  logic                  hold_prev = 1'b0;
  logic [FW-1:0]         prev_frame;
  logic [0:DN-1][DW-1:0] mdl_lanes;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.o_m_valid), 64'd1);
        chk("hold_frame", 64'({bus.o_m_lanes, bus.o_m_data}), 64'(prev_frame));
      end
      if (bus.o_m_valid && bus.i_m_ready) begin
        frames_seen++;
        chk("frame_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0)
          chk("frame", 64'({bus.o_m_lanes, bus.o_m_data}), 64'(exp_q.pop_front()));
      end
      if (bus.i_s_valid && bus.o_s_ready) begin
        cur_q.push_back(bus.i_s_data);
        if (cur_q.size() == DN || bus.i_s_last) begin
          mdl_lanes = '0;
          for (int i = 0; i < cur_q.size(); i++) mdl_lanes[i] = cur_q[i];
          exp_q.push_back({LW'(cur_q.size()), mdl_lanes});
          cur_q.delete();
        end
      end
      hold_prev  = bus.o_m_valid && !bus.i_m_ready;
      prev_frame = {bus.o_m_lanes, bus.o_m_data};
    end
  end

  // driver: inputs change 1 time unit after posedge; acceptance is sampled at negedge
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, output logic acc);
    bus.i_s_valid = v;
    bus.i_s_data  = d;
    bus.i_s_last  = l;
    @(negedge clk);
    acc = v && bus.o_s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic a;
    drive(1'b0, '0, 1'b0, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic                  acc, v, l, pending, closed;
  logic [DW-1:0]         d;
  logic [DW-1:0]         t1_vals [DN];
  logic [0:DN-1][DW-1:0] exp_lanes;
  int                    n_acc, sum, f0;

  initial begin
    t1_vals = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    rst_n = 1'b0;
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    bus.i_s_last  = 1'b0;
    bus.i_m_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.o_s_ready), 64'd0);
    chk("rst_valid", 64'(bus.o_m_valid), 64'd0);
    chk("rst_data", 64'(bus.o_m_data), 64'd0);
    chk("rst_lanes", 64'(bus.o_m_lanes), 64'd0);
    chk("rst_idx", 64'(bus.dbg_idx), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(bus.o_s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 64'(bus.o_s_ready), 64'd1);

    // full frame
    bus.i_m_ready = 1'b1;
    for (int i = 0; i < DN; i++) begin
      drive(1'b1, t1_vals[i], 1'b0, acc);
      chk("t1_accept", 64'(acc), 64'd1);
    end
    bus.i_s_valid = 1'b0;
    for (int i = 0; i < DN; i++) exp_lanes[i] = t1_vals[i];
    chk("t1_valid", 64'(bus.o_m_valid), 64'd1);
    chk("t1_lanes", 64'(bus.o_m_lanes), 64'd9);
    chk("t1_data", 64'(bus.o_m_data), 64'(exp_lanes));
    sum = 0;
    for (int i = 0; i < DN; i++) sum += int'(bus.o_m_data[i]);
    chk("t1_sum", 64'(sum), 64'd29);
    idle();
    chk("t1_pulse_end", 64'(bus.o_m_valid), 64'd0);

    // short frame
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd7, (i == 2), acc);
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    exp_lanes = '0;
    for (int i = 0; i < 3; i++) exp_lanes[i] = 3'd7;
    chk("t2_valid", 64'(bus.o_m_valid), 64'd1);
    chk("t2_lanes", 64'(bus.o_m_lanes), 64'd3);
    chk("t2_data", 64'(bus.o_m_data), 64'(exp_lanes));
    chk("t2_idx", 64'(bus.dbg_idx), 64'd0);
    idle();

    // last without valid is ignored
    for (int i = 0; i < 4; i++) drive(1'b1, DW'($urandom), 1'b0, acc);
    drive(1'b0, DW'($urandom), 1'b1, acc);
    chk("t6_idx", 64'(bus.dbg_idx), 64'd4);
    chk("t6_no_frame", 64'(bus.o_m_valid), 64'd0);
    chk("t6_state", 64'(bus.dbg_state), 64'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom), 1'b0, acc);
    bus.i_s_valid = 1'b0;
    chk("t6_valid", 64'(bus.o_m_valid), 64'd1);
    chk("t6_lanes", 64'(bus.o_m_lanes), 64'd9);
    idle();

    // stall fills both buffers
    bus.i_m_ready = 1'b0;
    n_acc = 0;
    d = DW'($urandom);
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, d, 1'b0, acc);
      if (acc) begin
        n_acc++;
        d = DW'($urandom);
        if (n_acc == 2 * DN) chk("t3_ready_fall", 64'(bus.o_s_ready), 64'd0);
      end
    end
    bus.i_s_valid = 1'b0;
    chk("t3_accepted", 64'(n_acc), 64'(2 * DN));
    chk("t3_valid", 64'(bus.o_m_valid), 64'd1);
    chk("t3_state_held", 64'(bus.dbg_state), 64'd1);
    bus.i_m_ready = 1'b1;
    idle();
    chk("t3_ready_back", 64'(bus.o_s_ready), 64'd1);
    chk("t3_second_valid", 64'(bus.o_m_valid), 64'd1);
    idle();
    chk("t3_drained", 64'(bus.o_m_valid), 64'd0);
    chk("t3_exp_empty", 64'(exp_q.size()), 64'd0);

    // continuous input, downstream always ready
    f0 = frames_seen;
    for (int i = 0; i < 10 * DN; i++) begin
      drive(1'b1, DW'($urandom), 1'b0, acc);
      chk("t4_no_gap", 64'(acc), 64'd1);
    end
    bus.i_s_valid = 1'b0;
    idle();
    chk("t4_frames", 64'(frames_seen - f0), 64'd10);
    // single-lane frames: drain and load coincide on every edge
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'($urandom), 1'b1, acc);
      chk("t4_coincide_valid", 64'(bus.o_m_valid), 64'd1);
      chk("t4_coincide_lanes", 64'(bus.o_m_lanes), 64'd1);
    end
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    idle();
    chk("t4_end_valid", 64'(bus.o_m_valid), 64'd0);

    // reset mid-frame
    for (int i = 0; i < 4; i++) drive(1'b1, DW'($urandom), 1'b0, acc);
    bus.i_s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    cur_q.delete();
    exp_q.delete();
    #1;
    chk("t5_ready", 64'(bus.o_s_ready), 64'd0);
    chk("t5_valid", 64'(bus.o_m_valid), 64'd0);
    chk("t5_data", 64'(bus.o_m_data), 64'd0);
    chk("t5_lanes", 64'(bus.o_m_lanes), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_ready_rise", 64'(bus.o_s_ready), 64'd1);
    for (int i = 0; i < DN; i++) drive(1'b1, DW'($urandom), 1'b0, acc);
    bus.i_s_valid = 1'b0;
    chk("t5_frame_valid", 64'(bus.o_m_valid), 64'd1);
    chk("t5_frame_lanes", 64'(bus.o_m_lanes), 64'd9);
    idle();

    // random traffic with random back-pressure
    pending = 1'b0;
    v = 1'b0;
    l = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.i_m_ready = ($urandom_range(0, 9) < 6);
      if (!pending) begin
        v = ($urandom_range(0, 9) < 7);
        d = DW'($urandom);
        l = ($urandom_range(0, 5) == 0);
      end
      drive(v, d, l, acc);
      pending = v && !acc;
    end

    // close the open frame and flush
    bus.i_m_ready = 1'b1;
    closed = 1'b0;
    for (int c = 0; c < 60 && !closed; c++) begin
      if (!pending) begin
        v = 1'b1;
        d = DW'($urandom);
        l = 1'b1;
      end
      drive(v, d, l, acc);
      pending = v && !acc;
      if (acc && l) closed = 1'b1;
    end
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    chk("final_close", 64'(closed), 64'd1);
    repeat (3) idle();
    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("final_partial_empty", 64'(cur_q.size()), 64'd0);
    chk("final_valid", 64'(bus.o_m_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
